cpu_controller: RTL and testbench
=================================

Name: cpu_controller

Overview:
- Sequencing controller for the 8-bit accumulator CPU; the control-side counterpart of the ALU.
- Drives the datapath strobes from the 3-bit opcode held in the instruction register.
- Consumes the ALU `is_zero` flag, which reflects the accumulator.
- Each instruction runs as an 8-phase cycle: fetch, decode, operand fetch, ALU/store.

Parameters:
- HALT_STICKY, 1:
  - 1 = HLT freezes the controller in OP_ADDR with halt held until reset.
  - 0 = halt pulses for one cycle in OP_ADDR and sequencing continues.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  phase advance enable; 0 stalls.
- opcode  in  3  instruction register opcode (0 HLT, 1 SKZ, 2 ADD, 3 AND, 4 XOR, 5 LDA, 6 STO, 7 JMP).
- zero  in  1  ALU `is_zero` (accumulator == 0).
- sel  out  1  memory address mux: 1 = PC, 0 = IR operand.
- rd  out  1  memory read enable.
- ld_ir  out  1  load instruction register.
- inc_pc  out  1  increment PC.
- ld_pc  out  1  load PC from IR operand.
- ld_ac  out  1  load accumulator from ALU rd.
- wr  out  1  memory write strobe.
- data_e  out  1  accumulator drives data bus.
- halt  out  1  CPU halted.
- phase  out  3  current phase (debug).

Behaviour:
- State is a 3-bit phase register, 0..7: INST_ADDR, INST_FETCH, INST_LOAD, IDLE, OP_ADDR, OP_FETCH, ALU_OP, STORE. STORE wraps to INST_ADDR.
- Reset:
  - rst=1 at a clk edge sets phase=INST_ADDR and clears the halted flag. rst has priority over en.
  - Mid-instruction reset abandons the instruction; there is no partial write recovery.
- Outputs are combinational from phase, opcode, zero, en and the halted flag.
- Reset outputs: sel=1, all other strobes 0, halt=0, phase=0.
- Advance: phase increments when en=1 and the controller is not halted. en=0 holds phase.
- Stall masking: while en=0, ld_ir, inc_pc, ld_pc, ld_ac and wr are forced 0. sel, rd and data_e follow the phase.
- ALUOP = opcode in {ADD, AND, XOR, LDA}.
- Per phase (unlisted outputs are 0):
  - INST_ADDR: sel=1.
  - INST_FETCH: sel=1, rd=1.
  - INST_LOAD: sel=1, rd=1, ld_ir=1.
  - IDLE: sel=1, rd=1.
  - OP_ADDR: inc_pc=1, or halt=1 with inc_pc=0 if opcode==HLT.
  - OP_FETCH: rd=ALUOP.
  - ALU_OP: rd=ALUOP; inc_pc=(opcode==SKZ && zero); ld_pc=(opcode==JMP); data_e=(opcode==STO).
  - STORE: rd=ALUOP, ld_ac=ALUOP, ld_pc=(opcode==JMP), wr=(opcode==STO), data_e=(opcode==STO).
- Throughput: exactly 8 enabled cycles per instruction. For a non-halting instruction, INST_ADDR recurs 8 enabled edges later.
- SKZ: zero is sampled combinationally in ALU_OP only. zero toggling in other phases has no effect.
- HLT with HALT_STICKY=1:
  - On the edge leaving OP_ADDR with opcode==HLT and en=1, the halted flag sets.
  - phase stays 4, halt=1, and all strobes stay 0 until rst.
  - en and opcode changes are ignored while halted.
- HLT with HALT_STICKY=0: halt=1 only during OP_ADDR, and sequencing continues normally.
- JMP: ld_pc is asserted in both ALU_OP and STORE. inc_pc is asserted in OP_ADDR as usual; the later load overrides.
- STO: data_e covers both ALU_OP and STORE so the bus is stable around the wr pulse.
- Invariants: wr and ld_ac are never both 1. ld_pc and inc_pc are never both 1 in the same cycle.

Test Plan:
1. rst=1 for 2 cycles, then en=1 with opcode=ADD(2), zero=0:
   - phase steps 0..7 then back to 0.
   - ld_ir=1 only at phase 2; inc_pc=1 only at phase 4; rd=1 at phases 1,2,3,5,6,7; ld_ac=1 only at phase 7; wr never 1.
2. opcode=STO(6):
   - data_e=1 at phases 6 and 7; wr=1 only at phase 7; rd=0 and ld_ac=0 at phases 5–7.
3. opcode=SKZ(1):
   - zero=1: inc_pc=1 at phases 4 and 6.
   - zero=0: inc_pc=1 at phase 4 only.
   - zero toggled during phase 5 with zero=0 at phase 6: no effect.
4. opcode=JMP(7):
   - ld_pc=1 at phases 6 and 7; inc_pc=1 at phase 4 only; wr=0 throughout.
5. opcode=HLT(0), HALT_STICKY=1:
   - At phase 4, halt=1 and inc_pc=0.
   - Over the next 20 cycles (en=1, opcode changed to ADD): phase stays 4, halt stays 1, all strobes 0.
   - rst=1 for one cycle: phase=0, halt=0.
   - With HALT_STICKY=0: halt=1 only during phase 4, and phase reaches 5 on the next edge.
6. en=0 held 3 cycles in phase 2 (opcode=ADD):
   - phase stays 2, ld_ir=0, sel=1 and rd=1 throughout.
   - After en returns to 1: ld_ir=1 for one cycle, then phase=3.
   - rst asserted during phase 6: next phase=0.

Source files
------------

// File: rtl/cpu_controller.sv
// Phase sequencer for the 8-bit accumulator CPU: eight phases per instruction,
// decoding the IR opcode into datapath strobes.
module cpu_controller #(
    parameter bit HALT_STICKY = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [2:0] opcode,
    input  logic       zero,
    output logic       sel,
    output logic       rd,
    output logic       ld_ir,
    output logic       inc_pc,
    output logic       ld_pc,
    output logic       ld_ac,
    output logic       wr,
    output logic       data_e,
    output logic       halt,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        InstAddr, InstFetch, InstLoad, Idle, OpAddr, OpFetch, AluOp, Store
    } phase_e;

    localparam logic [2:0] OpHlt = 3'd0;
    localparam logic [2:0] OpSkz = 3'd1;
    localparam logic [2:0] OpAdd = 3'd2;
    localparam logic [2:0] OpAnd = 3'd3;
    localparam logic [2:0] OpXor = 3'd4;
    localparam logic [2:0] OpLda = 3'd5;
    localparam logic [2:0] OpSto = 3'd6;
    localparam logic [2:0] OpJmp = 3'd7;

    phase_e phase_q;
    logic   halted_q;
    logic   alu_op;

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q  <= InstAddr;
            halted_q <= 1'b0;
        end else if (en && !halted_q) begin
            // A sticky halt parks the sequencer in OpAddr instead of advancing.
            if (HALT_STICKY && phase_q == OpAddr && opcode == OpHlt) begin
                halted_q <= 1'b1;
            end else begin
                phase_q <= phase_e'(phase_q + 3'd1);
            end
        end
    end

    assign alu_op = (opcode == OpAdd) || (opcode == OpAnd) ||
                    (opcode == OpXor) || (opcode == OpLda);
    assign phase  = phase_q;

    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        inc_pc = 1'b0;
        ld_pc  = 1'b0;
        ld_ac  = 1'b0;
        wr     = 1'b0;
        data_e = 1'b0;
        halt   = 1'b0;
        unique case (phase_q)
            InstAddr:  sel = 1'b1;
            InstFetch: begin
                sel = 1'b1;
                rd  = 1'b1;
            end
            InstLoad: begin
                sel   = 1'b1;
                rd    = 1'b1;
                ld_ir = 1'b1;
            end
            Idle: begin
                sel = 1'b1;
                rd  = 1'b1;
            end
            OpAddr: begin
                halt   = (opcode == OpHlt);
                inc_pc = (opcode != OpHlt);
            end
            OpFetch:   rd = alu_op;
            AluOp: begin
                rd     = alu_op;
                inc_pc = (opcode == OpSkz) && zero;
                ld_pc  = (opcode == OpJmp);
                data_e = (opcode == OpSto);
            end
            Store: begin
                rd     = alu_op;
                ld_ac  = alu_op;
                ld_pc  = (opcode == OpJmp);
                wr     = (opcode == OpSto);
                data_e = (opcode == OpSto);
            end
            default: ;
        endcase
        // Stalls suppress every state-changing strobe; address/bus controls stay live.
        if (!en) begin
            ld_ir  = 1'b0;
            inc_pc = 1'b0;
            ld_pc  = 1'b0;
            ld_ac  = 1'b0;
            wr     = 1'b0;
        end
        if (halted_q) begin
            sel    = 1'b0;
            rd     = 1'b0;
            ld_ir  = 1'b0;
            inc_pc = 1'b0;
            ld_pc  = 1'b0;
            ld_ac  = 1'b0;
            wr     = 1'b0;
            data_e = 1'b0;
            halt   = 1'b1;
        end
    end

endmodule

// File: tb/tb_cpu_controller.sv
// Self-checking bench for cpu_controller: sticky and non-sticky instances share
// stimulus and are compared against a phase-table reference model.
module tb_cpu_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       zero = 1'b0;
    logic [2:0] opcode = 3'd0;

    logic       s_sel, s_rd, s_ld_ir, s_inc_pc, s_ld_pc, s_ld_ac, s_wr, s_data_e, s_halt;
    logic [2:0] s_phase;
    logic       n_sel, n_rd, n_ld_ir, n_inc_pc, n_ld_pc, n_ld_ac, n_wr, n_data_e, n_halt;
    logic [2:0] n_phase;
    logic [11:0] v_s, v_n;

    int n_vec = 0;
    int n_err = 0;
    int m_ph  = 0;
    bit m_h   = 1'b0;
    int n_ph  = 0;

    cpu_controller #(.HALT_STICKY(1'b1)) dut_s (
        .clk(clk), .rst(rst), .en(en), .opcode(opcode), .zero(zero),
        .sel(s_sel), .rd(s_rd), .ld_ir(s_ld_ir), .inc_pc(s_inc_pc), .ld_pc(s_ld_pc),
        .ld_ac(s_ld_ac), .wr(s_wr), .data_e(s_data_e), .halt(s_halt), .phase(s_phase)
    );

    cpu_controller #(.HALT_STICKY(1'b0)) dut_n (
        .clk(clk), .rst(rst), .en(en), .opcode(opcode), .zero(zero),
        .sel(n_sel), .rd(n_rd), .ld_ir(n_ld_ir), .inc_pc(n_inc_pc), .ld_pc(n_ld_pc),
        .ld_ac(n_ld_ac), .wr(n_wr), .data_e(n_data_e), .halt(n_halt), .phase(n_phase)
    );

    assign v_s = {s_phase, s_sel, s_rd, s_ld_ir, s_inc_pc, s_ld_pc, s_ld_ac, s_wr, s_data_e,
                  s_halt};
    assign v_n = {n_phase, n_sel, n_rd, n_ld_ir, n_inc_pc, n_ld_pc, n_ld_ac, n_wr, n_data_e,
                  n_halt};

    always #5 clk = ~clk;

    // Expected {phase, sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt}.
    function automatic logic [11:0] exp_out(int ph, bit h, logic [2:0] op, logic z, logic e);
        logic       aluop;
        logic [8:0] s;
        if (h) return {3'd4, 9'b0_0000_0001};
        aluop = (op >= 3'd2 && op <= 3'd5);
        s[8] = (ph < 4);
        s[7] = (ph >= 1 && ph <= 3) || (ph >= 5 && aluop);
        s[6] = (ph == 2);
        s[5] = (ph == 4 && op != 3'd0) || (ph == 6 && op == 3'd1 && z);
        s[4] = (ph >= 6 && op == 3'd7);
        s[3] = (ph == 7 && aluop);
        s[2] = (ph == 7 && op == 3'd6);
        s[1] = (ph >= 6 && op == 3'd6);
        s[0] = (ph == 4 && op == 3'd0);
        if (!e) s[6:2] = 5'b0;
        return {3'(ph), s};
    endfunction

    task automatic drive(input logic r, input logic e, input logic z, input logic [2:0] op);
        @(negedge clk);
        rst = r;
        en = e;
        zero = z;
        opcode = op;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_ph = 0;
            m_h  = 1'b0;
            n_ph = 0;
        end else if (en) begin
            if (!m_h) begin
                if (m_ph == 4 && opcode == 3'd0) m_h = 1'b1;
                else m_ph = (m_ph + 1) % 8;
            end
            n_ph = (n_ph + 1) % 8;
        end
    endtask

    task automatic test_reset();
        drive(1'b1, 1'($urandom), 1'($urandom), 3'($urandom));
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(1'(i == 0), 1'b1, 1'($urandom), 3'd2);
            n_vec++;
            if (v_s !== 12'b000_1000_0000_0) begin
                n_err++;
                $display("FAIL reset_sticky got=%b exp=%b", v_s, 12'b000_1000_0000_0);
            end
            n_vec++;
            if (v_n !== 12'b000_1000_0000_0) begin
                n_err++;
                $display("FAIL reset_nonsticky got=%b exp=%b", v_n, 12'b000_1000_0000_0);
            end
            tick();
        end
    endtask

    // Runs one full instruction from reset with a fixed opcode and zero pattern.
    task automatic test_opcode(input string name, input logic [2:0] op, input int zmode);
        logic z;
        drive(1'b1, 1'b1, 1'b0, op);
        tick();
        for (int i = 0; i <= 8; i++) begin
            if (zmode == 0) z = 1'b0;
            else if (zmode == 1) z = 1'b1;
            else z = (i == 6) ? 1'b0 : 1'($urandom);
            drive(1'b0, 1'b1, z, op);
            n_vec++;
            if (s_phase !== 3'(i % 8)) begin
                n_err++;
                $display("FAIL %s_phase step=%0d got=%0d exp=%0d", name, i, s_phase, i % 8);
            end
            n_vec++;
            if (v_s !== exp_out(m_ph, m_h, opcode, zero, en)) begin
                n_err++;
                $display("FAIL %s_sticky ph=%0d got=%b exp=%b", name, m_ph, v_s,
                         exp_out(m_ph, m_h, opcode, zero, en));
            end
            n_vec++;
            if (v_n !== exp_out(n_ph, 1'b0, opcode, zero, en)) begin
                n_err++;
                $display("FAIL %s_nonsticky ph=%0d got=%b exp=%b", name, n_ph, v_n,
                         exp_out(n_ph, 1'b0, opcode, zero, en));
            end
            tick();
        end
    endtask

    task automatic test_halt();
        drive(1'b1, 1'b1, 1'b0, 3'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 1'($urandom), 3'd0);
            tick();
        end
        drive(1'b0, 1'b1, 1'($urandom), 3'd0);
        n_vec++;
        if ({s_phase, s_halt, s_inc_pc, n_halt, n_inc_pc} !== 7'b100_1010) begin
            n_err++;
            $display("FAIL halt_entry got=%b exp=%b",
                     {s_phase, s_halt, s_inc_pc, n_halt, n_inc_pc}, 7'b100_1010);
        end
        tick();
        drive(1'b0, 1'b1, 1'($urandom), 3'd0);
        n_vec++;
        if ({n_phase, n_halt} !== 4'b101_0) begin
            n_err++;
            $display("FAIL halt_nonsticky_moves got=%b exp=%b", {n_phase, n_halt}, 4'b1010);
        end
        tick();
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'b1, 1'($urandom), 3'd2);
            n_vec++;
            if (v_s !== 12'b100_0000_0000_1) begin
                n_err++;
                $display("FAIL halt_hold cyc=%0d got=%b exp=%b", i, v_s, 12'b100_0000_0000_1);
            end
            tick();
        end
        drive(1'b1, 1'b1, 1'b0, 3'd2);
        tick();
        drive(1'b0, 1'b0, 1'b0, 3'd2);
        n_vec++;
        if ({s_phase, s_halt} !== 4'b000_0) begin
            n_err++;
            $display("FAIL halt_release got=%b exp=%b", {s_phase, s_halt}, 4'b0000);
        end
    endtask

    task automatic test_stall();
        drive(1'b1, 1'b1, 1'b0, 3'd2);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b1, 1'($urandom), 3'd2);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'($urandom), 3'd2);
            n_vec++;
            if ({s_phase, s_ld_ir, s_sel, s_rd} !== 6'b010_011) begin
                n_err++;
                $display("FAIL stall_hold cyc=%0d got=%b exp=%b", i,
                         {s_phase, s_ld_ir, s_sel, s_rd}, 6'b010011);
            end
            tick();
        end
        drive(1'b0, 1'b1, 1'b0, 3'd2);
        n_vec++;
        if ({s_phase, s_ld_ir} !== 4'b010_1) begin
            n_err++;
            $display("FAIL stall_resume got=%b exp=%b", {s_phase, s_ld_ir}, 4'b0101);
        end
        for (int ph = 3; ph <= 6; ph++) begin
            tick();
            drive(1'b0, 1'b1, 1'($urandom), 3'd2);
            n_vec++;
            if (s_phase !== 3'(ph)) begin
                n_err++;
                $display("FAIL stall_advance got=%0d exp=%0d", s_phase, ph);
            end
        end
        drive(1'b1, 1'b1, 1'b0, 3'd2);
        tick();
        drive(1'b0, 1'b1, 1'b0, 3'd2);
        n_vec++;
        if (s_phase !== 3'd0) begin
            n_err++;
            $display("FAIL stall_midreset got=%0d exp=0", s_phase);
        end
    endtask

    task automatic test_random();
        drive(1'b1, 1'b1, 1'b0, 3'd2);
        tick();
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 3) != 0),
                  1'($urandom), 3'($urandom));
            n_vec++;
            if (v_s !== exp_out(m_ph, m_h, opcode, zero, en)) begin
                n_err++;
                $display("FAIL random_sticky cyc=%0d got=%b exp=%b", i, v_s,
                         exp_out(m_ph, m_h, opcode, zero, en));
            end
            n_vec++;
            if (v_n !== exp_out(n_ph, 1'b0, opcode, zero, en)) begin
                n_err++;
                $display("FAIL random_nonsticky cyc=%0d got=%b exp=%b", i, v_n,
                         exp_out(n_ph, 1'b0, opcode, zero, en));
            end
            n_vec++;
            if ((s_wr && s_ld_ac) || (s_ld_pc && s_inc_pc) || (n_wr && n_ld_ac) ||
                (n_ld_pc && n_inc_pc)) begin
                n_err++;
                $display("FAIL random_invariant cyc=%0d got=%b%b exp=00", i, v_s, v_n);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_opcode("add", 3'd2, 2);
        test_opcode("sto", 3'd6, 2);
        test_opcode("skz_z1", 3'd1, 1);
        test_opcode("skz_z0", 3'd1, 0);
        test_opcode("skz_tog", 3'd1, 2);
        test_opcode("jmp", 3'd7, 2);
        test_halt();
        test_stall();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
